// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver.
// Serial line in, parallel word out. Word length, parity mode and stop-bit
// count are parameters. The block adds an input synchroniser, a 3-sample
// majority vote per bit, parity/framing error flags and break detection.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 217,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  output logic                 o_RX_DV,
  output logic [DATA_BITS-1:0] o_RX_Byte,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Busy
);

  localparam int CW  = $clog2(CLKS_PER_BIT);
  localparam int MID = (CLKS_PER_BIT - 1) / 2;
  localparam int BW  = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0    = CW'(MID - 1);
  localparam logic [CW-1:0] CNT_S1    = CW'(MID);
  localparam logic [CW-1:0] CNT_S2    = CW'(MID + 1);
  localparam logic [BW-1:0] IDX_DLAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] IDX_SLAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_BRK
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [1:0]             hist;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [BW-1:0]          bit_idx, idx_nxt;
  logic                   samp_a, samp_b;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_err_q, frm_err_q, seen_one;
  logic                   samp_pt, voted, line_vote, brk_now, done;

  // Pin synchroniser; resets to the idle (high) line level.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], i_RX_Serial};
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  // Bit value = majority of the samples taken at MID-1, MID and MID+1.
  assign samp_pt   = (cnt == CNT_S2);
  assign voted     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  // Running 3-tap vote used while waiting for the line to recover from a break.
  assign line_vote = (hist[0] & hist[1]) | (hist[0] & rx_s) | (hist[1] & rx_s);
  // Break: every bit after the start bit, including the final stop bit, was 0.
  assign brk_now   = ~seen_one & ~voted;
  assign o_Busy    = (state != S_IDLE);

  // State register.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= idx_nxt;
    end
  end

  // Next state, bit-time counter and bit index.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    idx_nxt   = bit_idx;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = S_START;
      end
      S_START: begin
        if (samp_pt) begin
          idx_nxt   = '0;
          state_nxt = voted ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (samp_pt) begin
          if (bit_idx == IDX_DLAST) begin
            idx_nxt   = '0;
            state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (samp_pt) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (samp_pt) begin
          if (bit_idx == IDX_SLAST) begin
            done    = 1'b1;
            idx_nxt = '0;
            if (brk_now) begin
              state_nxt = S_BRK;
              cnt_nxt   = '0;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      S_BRK: begin
        // Count consecutive high votes; one full bit time of idle ends the break.
        if (!line_vote)            cnt_nxt   = '0;
        else if (cnt == CNT_LAST)  state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sample capture, shift register and per-frame error accumulation.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      samp_a    <= 1'b1;
      samp_b    <= 1'b1;
      hist      <= 2'b11;
      shreg     <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      seen_one  <= 1'b0;
    end else begin
      hist <= {hist[0], rx_s};
      if (cnt == CNT_S0) samp_a <= rx_s;
      if (cnt == CNT_S1) samp_b <= rx_s;
      if (state == S_START) begin
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
        seen_one  <= 1'b0;
      end
      if (samp_pt) begin
        case (state)
          S_DATA: begin
            shreg    <= {voted, shreg[DATA_BITS-1:1]};
            seen_one <= seen_one | voted;
          end
          S_PAR: begin
            par_err_q <= ((^shreg) ^ voted) != ODD;
            seen_one  <= seen_one | voted;
          end
          S_STOP: begin
            if (!voted) frm_err_q <= 1'b1;
            seen_one <= seen_one | voted;
          end
          default: ;
        endcase
      end
    end
  end

  // Output word and flags; they change only in the o_RX_DV cycle.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_RX_DV      <= 1'b0;
      o_RX_Byte    <= '0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_RX_DV <= done;
      if (done) begin
        o_RX_Byte    <= shreg;
        o_Parity_Err <= par_err_q;
        o_Frame_Err  <= frm_err_q | ~voted;
        o_Break      <= brk_now;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three channels (8N1, 7E1, 8N2) at 16 clocks/bit.
module tb_uart_rx_cfg;
  localparam int CPB  = 16;
  localparam int MID  = (CPB - 1) / 2;
  localparam int SYNC = 2;
  localparam int NV   = 12;

  typedef struct {
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
  } rec_t;

  typedef struct {
    int         ch;
    logic [8:0] data;
    logic       flip;
    logic [1:0] stops;
    rec_t       exp;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [2:0] rx;
  logic [2:0] dv, pe, fe, brk, busy;
  logic [7:0] byte0, byte2;
  logic [6:0] byte1;

  int checks = 0;
  int errors = 0;
  rec_t mon [3][128];
  int wr [3] = '{0, 0, 0};
  int rd [3] = '{0, 0, 0};
  vec_t tv [NV];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_8n1 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx[0]), .o_RX_DV(dv[0]), .o_RX_Byte(byte0),
    .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(brk[0]), .o_Busy(busy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(SYNC)) u_7e1 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx[1]), .o_RX_DV(dv[1]), .o_RX_Byte(byte1),
    .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(brk[1]), .o_Busy(busy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2), .SYNC_STAGES(SYNC)) u_8n2 (
    .i_Clock(clk), .i_Reset(rst), .i_RX_Serial(rx[2]), .o_RX_DV(dv[2]), .o_RX_Byte(byte2),
    .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(brk[2]), .o_Busy(busy[2]));

  // Record every o_RX_DV cycle per channel.
  always @(negedge clk) begin
    if (dv[0]) begin mon[0][wr[0] % 128] <= '{{1'b0, byte0}, pe[0], fe[0], brk[0]}; wr[0] <= wr[0] + 1; end
    if (dv[1]) begin mon[1][wr[1] % 128] <= '{{2'b0, byte1}, pe[1], fe[1], brk[1]}; wr[1] <= wr[1] + 1; end
    if (dv[2]) begin mon[2][wr[2] % 128] <= '{{1'b0, byte2}, pe[2], fe[2], brk[2]}; wr[2] <= wr[2] + 1; end
  end

  function automatic int nbits(input int ch);
    return (ch == 1) ? 7 : 8;
  endfunction

  function automatic int nstop(input int ch);
    return (ch == 2) ? 2 : 1;
  endfunction

  function automatic logic [8:0] get_byte(input int ch);
    case (ch)
      0:       return {1'b0, byte0};
      1:       return {2'b0, byte1};
      default: return {1'b0, byte2};
    endcase
  endfunction

  // Reference: expected record from the bits actually put on the line.
  function automatic rec_t model(input int ch, input logic [8:0] data, input logic flip,
                                 input logic [1:0] stops);
    rec_t r;
    logic [8:0] d;
    logic parbit;
    logic stops_zero;
    d = (ch == 1) ? (data & 9'h07F) : (data & 9'h0FF);
    parbit = (ch == 1) ? ((^d) ^ flip) : 1'b0;
    stops_zero = (stops[0] == 1'b0) && (nstop(ch) == 1 || stops[1] == 1'b0);
    r.data = d;
    r.pe   = (ch == 1) && flip;
    r.fe   = (stops[0] == 1'b0) || (nstop(ch) == 2 && stops[1] == 1'b0);
    r.brk  = (d == 9'd0) && !parbit && stops_zero;
    return r;
  endfunction

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic expect_rec(input string name, input int ch, input rec_t e);
    rec_t a;
    checks++;
    if (wr[ch] - rd[ch] < 1) begin
      errors++;
      $display("FAIL %s: no o_RX_DV on ch%0d, expected word 0x%0h", name, ch, e.data);
      return;
    end
    a = mon[ch][rd[ch] % 128];
    rd[ch]++;
    chk({name, ".byte"}, a.data, e.data);
    chk({name, ".par"},  {8'd0, a.pe},  {8'd0, e.pe});
    chk({name, ".frm"},  {8'd0, a.fe},  {8'd0, e.fe});
    chk({name, ".brk"},  {8'd0, a.brk}, {8'd0, e.brk});
  endtask

  task automatic expect_none(input string name, input int ch);
    chk_rng({name, ".extra_dv"}, wr[ch] - rd[ch], 0, 0);
  endtask

  // Drive one frame; noise_bit >= 0 inverts that bit for one clock mid-bit.
  task automatic send_frame(input int ch, input logic [8:0] d, input logic flip,
                            input logic [1:0] stops, input int noise_bit);
    logic bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < nbits(ch); i++) bits.push_back(d[i]);
    if (ch == 1) bits.push_back((^(d & 9'h07F)) ^ flip);
    for (int s = 0; s < nstop(ch); s++) bits.push_back(stops[s]);
    for (int i = 0; i < bits.size(); i++) begin
      for (int c = 0; c < CPB; c++) begin
        rx[ch] = (i == noise_bit && c == CPB / 2) ? ~bits[i] : bits[i];
        @(negedge clk);
      end
    end
    rx[ch] = 1'b1;
  endtask

  initial begin
    int n, g, bc, ch;
    logic [8:0] d;
    logic fl;
    logic [1:0] st;

    tv[0]  = '{0, 9'h0A5, 1'b0, 2'b11, '{9'h0A5, 1'b0, 1'b0, 1'b0}};
    tv[1]  = '{0, 9'h000, 1'b0, 2'b11, '{9'h000, 1'b0, 1'b0, 1'b0}};
    tv[2]  = '{0, 9'h0FF, 1'b0, 2'b10, '{9'h0FF, 1'b0, 1'b1, 1'b0}};
    tv[3]  = '{0, 9'h000, 1'b0, 2'b00, '{9'h000, 1'b0, 1'b1, 1'b1}};
    tv[4]  = '{1, 9'h037, 1'b1, 2'b11, '{9'h037, 1'b1, 1'b0, 1'b0}};
    tv[5]  = '{1, 9'h037, 1'b0, 2'b11, '{9'h037, 1'b0, 1'b0, 1'b0}};
    tv[6]  = '{1, 9'h000, 1'b0, 2'b11, '{9'h000, 1'b0, 1'b0, 1'b0}};
    tv[7]  = '{1, 9'h07F, 1'b0, 2'b10, '{9'h07F, 1'b0, 1'b1, 1'b0}};
    tv[8]  = '{2, 9'h081, 1'b0, 2'b01, '{9'h081, 1'b0, 1'b1, 1'b0}};
    tv[9]  = '{2, 9'h081, 1'b0, 2'b10, '{9'h081, 1'b0, 1'b1, 1'b0}};
    tv[10] = '{2, 9'h081, 1'b0, 2'b11, '{9'h081, 1'b0, 1'b0, 1'b0}};
    tv[11] = '{2, 9'h000, 1'b0, 2'b00, '{9'h000, 1'b0, 1'b1, 1'b1}};

    rst = 1'b1;
    rx  = 3'b111;
    wait_clks(3);
    chk("rst.dv",   {6'd0, dv},   9'd0);
    chk("rst.byte", byte0,        9'd0);
    chk("rst.flag", {3'd0, pe, fe}, 9'd0);
    chk("rst.busy", {6'd0, busy}, 9'd0);
    rst = 1'b0;
    wait_clks(2);

    // Single frames from the table.
    for (int i = 0; i < NV; i++) begin
      send_frame(tv[i].ch, tv[i].data, tv[i].flip, tv[i].stops, -1);
      wait_clks(3 * CPB);
      expect_rec($sformatf("vec%0d", i), tv[i].ch, tv[i].exp);
      expect_none($sformatf("vec%0d", i), tv[i].ch);
    end

    // Back-to-back 0xA5, 0x3C with latency and inter-frame busy gap.
    fork
      begin
        send_frame(0, 9'h0A5, 1'b0, 2'b11, -1);
        send_frame(0, 9'h03C, 1'b0, 2'b11, -1);
      end
      begin
        n = 0;
        while (!dv[0] && n < 400) begin @(negedge clk); n++; end
        chk_rng("b2b.latency", n, SYNC + MID + 2 + 9 * CPB - 1, SYNC + MID + 2 + 9 * CPB + 1);
        g = 0;
        while (!busy[0] && g < 200) begin @(negedge clk); g++; end
        chk_rng("b2b.busy_gap", g, 1, CPB - 1);
      end
    join
    wait_clks(3 * CPB);
    expect_rec("b2b0", 0, '{9'h0A5, 1'b0, 1'b0, 1'b0});
    expect_rec("b2b1", 0, '{9'h03C, 1'b0, 1'b0, 1'b0});
    expect_none("b2b", 0);

    // 5-clock low glitch on an idle line.
    bc = 0;
    for (int c = 0; c < 48; c++) begin
      rx[0] = (c < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy[0]) bc++;
    end
    chk_rng("glitch.busy_cycles", bc, 1, MID + 2);
    chk("glitch.busy_end", {8'd0, busy[0]}, 9'd0);
    chk("glitch.byte", {1'b0, byte0}, 9'h03C);
    chk("glitch.flags", {6'd0, pe[0], fe[0], brk[0]}, 9'd0);
    expect_none("glitch", 0);

    // Break: 20 bit times low, 2 high, then a normal frame.
    rx[0] = 1'b0;
    wait_clks(20 * CPB);
    rx[0] = 1'b1;
    wait_clks(2 * CPB);
    send_frame(0, 9'h05A, 1'b0, 2'b11, -1);
    wait_clks(3 * CPB);
    expect_rec("break", 0, '{9'h000, 1'b0, 1'b1, 1'b1});
    expect_rec("after_break", 0, '{9'h05A, 1'b0, 1'b0, 1'b0});
    expect_none("break", 0);

    // Reset during data bit 3 of 0xFF.
    fork
      send_frame(0, 9'h0FF, 1'b0, 2'b11, -1);
      begin
        wait_clks(4 * CPB + CPB / 2);
        rst = 1'b1;
        #2;
        chk("mid_rst.byte0", {1'b0, byte0}, 9'd0);
        chk("mid_rst.byte1", {2'b0, byte1}, 9'd0);
        chk("mid_rst.flags", {6'd0, pe[0], fe[0], brk[0]}, 9'd0);
        chk("mid_rst.busy", {8'd0, busy[0]}, 9'd0);
        wait_clks(2);
        rst = 1'b0;
      end
    join
    wait_clks(3 * CPB);
    expect_none("aborted", 0);

    // Clean frames with one-clock noise at mid-bit.
    send_frame(0, 9'h03C, 1'b0, 2'b11, 3);
    wait_clks(3 * CPB);
    expect_rec("noise_hi", 0, '{9'h03C, 1'b0, 1'b0, 1'b0});
    send_frame(0, 9'h03C, 1'b0, 2'b11, 1);
    wait_clks(3 * CPB);
    expect_rec("noise_lo", 0, '{9'h03C, 1'b0, 1'b0, 1'b0});

    // Randomised frames against the reference model.
    for (int i = 0; i < 30; i++) begin
      ch = $urandom_range(0, 2);
      d  = 9'($urandom);
      fl = (ch == 1) && ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      if ($urandom_range(0, 7) == 0) begin
        d  = 9'd0;
        fl = 1'b0;
        st = 2'b00;
      end
      send_frame(ch, d, fl, st, -1);
      wait_clks(3 * CPB);
      expect_rec($sformatf("rnd%0d", i), ch, model(ch, d, fl, st));
    end

    for (int c = 0; c < 3; c++) expect_none($sformatf("final_ch%0d", c), c);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
